pc_controller: RTL
==================

PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002: Parameter TRAP_VEC, default 32'h0000_0100, is the PC value loaded on a trap or a fetch timeout.
REQ-003: Parameter PC_STEP, default 32'd1, is the sequential increment (word-addressed).
REQ-004: Parameter TIMEOUT, default 8, is the number of FETCH cycles without imem_ack before a fault; legal range 2..255.
REQ-005: clk  in  1  single clock; all state updates on its rising edge.
REQ-006: rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007: imem_req  out  1  fetch request to instruction memory.
REQ-008: imem_addr  out  32  fetch address; equals pc whenever imem_req=1.
REQ-009: imem_ack  in  1  instruction memory has accepted and returned the fetch.
REQ-010: instr_valid  out  1  fetched instruction is available to the datapath.
REQ-011: stall  in  1  datapath cannot consume the instruction; hold ISSUE.
REQ-012: branch_req / branch_target  in  1 / 32  taken-branch redirect.
REQ-013: jump_req / jump_target  in  1 / 32  unconditional jump redirect.
REQ-014: trap_req  in  1  trap/exception redirect to TRAP_VEC.
REQ-015: pc  out  32  current program counter (registered).
REQ-016: pc_sel  out  2  source of the last pc update: 00 increment, 01 branch, 10 jump, 11 trap/fault (registered).
REQ-017: fault  out  1  one-cycle pulse on fetch timeout.

Function
REQ-018: The FSM SHALL have exactly the states RST, FETCH, ISSUE and FAULT.
REQ-019: RST -> FETCH unconditionally on the first cycle after rst_n=1; in RST all request and valid outputs = 0.
REQ-020: FETCH: imem_req=1 and imem_addr=pc; imem_ack=1 -> ISSUE next cycle, with the wait counter cleared.
REQ-021: FETCH without ack: the wait counter increments each cycle; when it reaches TIMEOUT-1 without ack -> FAULT.
REQ-022: FETCH with trap_req=1: trap wins over a same-cycle ack; pc<=TRAP_VEC, pc_sel<=11, wait counter cleared, stay in FETCH; imem_req drops for 0 cycles (the new address is presented next cycle).
REQ-023: ISSUE: instr_valid=1 and imem_req=0.
REQ-024: ISSUE, stall=0: pc updates with priority trap > jump > branch > increment (pc+PC_STEP), pc_sel set accordingly, -> FETCH.
REQ-025: ISSUE, stall=1: pc, pc_sel and instr_valid hold, stay in ISSUE; branch_req and jump_req are ignored while stalled.
REQ-026: ISSUE, stall=1 and trap_req=1: trap overrides the stall and applies as in REQ-024.
REQ-027: FAULT lasts exactly one cycle: fault=1, pc<=TRAP_VEC, pc_sel<=11, -> FETCH.
REQ-028: Increment SHALL wrap modulo 2^32 (32'hFFFF_FFFF + 1 = 0); no overflow flag.
REQ-029: branch_req, jump_req and trap_req are sampled only in the states named above; asserting them in other states has no effect.
REQ-030: Latency: ack in cycle N -> instr_valid in N+1 -> new pc and imem_req in N+2 (stall=0).

Reset
REQ-031: With rst_n=0 at a clock edge: state<=RST, pc<=RESET_PC, pc_sel<=00, wait counter<=0, and imem_req, instr_valid and fault all 0 from the next cycle, regardless of the current state, including mid-fetch and mid-stall.
REQ-032: An imem_ack arriving during or after reset, before a new request, SHALL be ignored.

Verification
REQ-033: Reset then ack on every fetch -> pc sequence 0,1,2,3 with pc_sel=00; instr_valid pulses every 2nd cycle.
REQ-034: In ISSUE, branch_req=1, target 32'h40, and jump_req=1, target 32'h80 -> pc=32'h80, pc_sel=10; next imem_addr=32'h80.
REQ-035: No ack for 8 FETCH cycles (TIMEOUT=8) -> fault pulses for 1 cycle, pc=32'h100, pc_sel=11, FETCH resumes at 32'h100.
REQ-036: stall=1 for 3 cycles in ISSUE with branch_req=1 -> pc unchanged, instr_valid held for 3 cycles; branch ignored.
REQ-037: pc=32'hFFFF_FFFF, ack, no redirect -> pc=0, pc_sel=00.
REQ-038: rst_n=0 while in FETCH with imem_ack=1 in the same cycle -> next cycle pc=RESET_PC, imem_req=0, instr_valid=0; ack discarded.

Source files
------------

// File: rtl/pc_controller.sv
// -----------------------------------------------------------------------------
// pc_controller
// Program-counter sequencer for a simple in-order fetch front end. It walks a
// four-state machine (RST -> FETCH -> ISSUE -> FETCH ...). Instruction-memory
// timeouts divert through a one-cycle FAULT state to the trap vector.
//
// Ports
//   clk            in   1   single clock, rising-edge active
//   rst_n          in   1   synchronous active-low reset
//   imem_req       out  1   fetch request (high in FETCH)
//   imem_addr      out  32  fetch address (always the current pc)
//   imem_ack       in   1   fetch accepted and instruction returned
//   instr_valid    out  1   instruction available to datapath (high in ISSUE)
//   stall          in   1   datapath cannot consume the instruction
//   branch_req     in   1   taken-branch redirect request
//   branch_target  in   32  branch destination
//   jump_req       in   1   unconditional jump redirect request
//   jump_target    in   32  jump destination
//   trap_req       in   1   trap/exception redirect to TRAP_VEC
//   pc             out  32  current program counter (registered)
//   pc_sel         out  2   source of last pc update: 00 inc, 01 br, 10 jmp, 11 trap/fault
//   fault          out  1   one-cycle pulse on fetch timeout
// -----------------------------------------------------------------------------
module pc_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter logic [31:0] PC_STEP  = 32'd1,
   parameter int unsigned TIMEOUT  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        branch_req,
   input  logic [31:0] branch_target,
   input  logic        jump_req,
   input  logic [31:0] jump_target,
   input  logic        trap_req,
   output logic [31:0] pc,
   output logic [1:0]  pc_sel,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [1:0] SEL_INC  = 2'b00;
   localparam logic [1:0] SEL_BR   = 2'b01;
   localparam logic [1:0] SEL_JMP  = 2'b10;
   localparam logic [1:0] SEL_TRAP = 2'b11;

   // Last wait-count value tolerated before the fetch is declared dead.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [1:0]  r_pc_sel;
   logic [1:0]  w_pc_sel_nxt;
   logic [7:0]  r_wait;
   logic [7:0]  w_wait_nxt;

   // State, pc, pc_sel and wait-counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_RST;
         r_pc     <= RESET_PC;
         r_pc_sel <= SEL_INC;
         r_wait   <= 8'd0;
      end else begin
         r_state  <= w_next_state;
         r_pc     <= w_pc_nxt;
         r_pc_sel <= w_pc_sel_nxt;
         r_wait   <= w_wait_nxt;
      end
   end

   // Next-state and next-pc selection.
   always_comb begin
      w_next_state = r_state;
      w_pc_nxt     = r_pc;
      w_pc_sel_nxt = r_pc_sel;
      w_wait_nxt   = r_wait;
      case (r_state)
         ST_RST: begin
            // Any ack seen here belongs to a request from before reset.
            w_next_state = ST_FETCH;
            w_wait_nxt   = 8'd0;
         end
         ST_FETCH: begin
            if (trap_req) begin
               // Trap beats a same-cycle ack; refetch from the vector.
               w_pc_nxt     = TRAP_VEC;
               w_pc_sel_nxt = SEL_TRAP;
               w_wait_nxt   = 8'd0;
            end else if (imem_ack) begin
               w_next_state = ST_ISSUE;
               w_wait_nxt   = 8'd0;
            end else if (r_wait == WAIT_LAST) begin
               w_next_state = ST_FAULT;
               w_wait_nxt   = 8'd0;
            end else begin
               w_wait_nxt   = r_wait + 8'd1;
            end
         end
         ST_ISSUE: begin
            if (trap_req) begin
               // Trap applies even while stalled.
               w_pc_nxt     = TRAP_VEC;
               w_pc_sel_nxt = SEL_TRAP;
               w_next_state = ST_FETCH;
            end else if (stall) begin
               // Hold everything; branch/jump are not sampled while stalled.
               w_next_state = ST_ISSUE;
            end else if (jump_req) begin
               w_pc_nxt     = jump_target;
               w_pc_sel_nxt = SEL_JMP;
               w_next_state = ST_FETCH;
            end else if (branch_req) begin
               w_pc_nxt     = branch_target;
               w_pc_sel_nxt = SEL_BR;
               w_next_state = ST_FETCH;
            end else begin
               // 32-bit add wraps modulo 2^32 by construction.
               w_pc_nxt     = r_pc + PC_STEP;
               w_pc_sel_nxt = SEL_INC;
               w_next_state = ST_FETCH;
            end
         end
         ST_FAULT: begin
            w_pc_nxt     = TRAP_VEC;
            w_pc_sel_nxt = SEL_TRAP;
            w_next_state = ST_FETCH;
         end
         default: begin
            w_next_state = ST_RST;
         end
      endcase
   end

   // Moore output decode from the registered state.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      fault       = 1'b0;
      case (r_state)
         ST_RST: begin
            imem_req    = 1'b0;
         end
         ST_FETCH: begin
            imem_req    = 1'b1;
         end
         ST_ISSUE: begin
            instr_valid = 1'b1;
         end
         ST_FAULT: begin
            fault       = 1'b1;
         end
         default: begin
            imem_req    = 1'b0;
         end
      endcase
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign pc_sel    = r_pc_sel;

endmodule
